// File: rtl/cas_player_if.sv
// Download port from hps_io into the cassette player.
// dn_wr is a one-cycle byte strobe, only meaningful while dn_go is high; there is no backpressure and the sink accepts every strobe.
interface cas_player_if #(
   parameter int ADDR_W = 14
);
   logic              dn_go;
   logic              dn_wr;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic [7:0]        dn_idx;

   modport master (output dn_go, dn_wr, dn_addr, dn_data, dn_idx);
   modport slave  (input  dn_go, dn_wr, dn_addr, dn_data, dn_idx);
endinterface

// File: rtl/cas_player.sv
// Cassette playback engine: buffers a .CAS download, then replays it as a
// Level II 500-baud pulse train (clock pulse + optional data pulse per bit cell).
module cas_player #(
   parameter int          ADDR_W  = 14,
   parameter logic [7:0]  CAS_IDX = 8'd1,
   parameter int          CELL_T  = 3560,
   parameter int          PULSE_T = 228
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic            ce,
   cas_player_if.slave     dn,
   input  logic            motor,
   input  logic            rewind,
   output logic            cas_bit,
   output logic            busy,
   output logic            done,
   output logic [ADDR_W:0] length,
   output logic [ADDR_W:0] pos,
   output logic [2:0]      dbg_state
);

   localparam int T_W = $clog2(CELL_T);
   localparam logic [T_W-1:0]  T_LAST  = T_W'(CELL_T - 1);
   localparam logic [T_W-1:0]  T_PULSE = T_W'(PULSE_T);
   localparam logic [T_W-1:0]  T_DATA0 = T_W'(CELL_T / 2);
   localparam logic [T_W-1:0]  T_DATA1 = T_W'(CELL_T / 2 + PULSE_T);
   localparam logic [T_W-1:0]  T_ONE   = T_W'(1);
   localparam logic [ADDR_W:0] POS_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_CELL  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic              sel, adv, cell_end, byte_end, tape_end;
   logic              fetch_ph, cas_nxt, rd_en;
   logic [T_W-1:0]    t, t_nxt;
   logic [2:0]        bit_cnt, bit_cnt_nxt;
   logic [7:0]        sr, sr_nxt, rd_q;
   logic [ADDR_W:0]   pos_nxt, length_nxt, pos_inc, wr_end;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        mem [2**ADDR_W];

   assign sel      = dn.dn_go && (dn.dn_idx == CAS_IDX);
   assign adv      = (state == S_CELL) && ce && motor;
   assign cell_end = adv && (t == T_LAST);
   assign byte_end = cell_end && (bit_cnt == 3'd0);
   assign pos_inc  = pos + POS_ONE;
   assign tape_end = byte_end && (pos_inc == length);
   assign wr_end   = {1'b0, dn.dn_addr} + POS_ONE;

   // FETCH reads byte pos; the first cell of each byte prefetches pos+1 into rd_q.
   assign rd_en   = ((state == S_FETCH) && !fetch_ph) ||
                    ((state == S_CELL) && (bit_cnt == 3'd7) && (t == '0));
   assign rd_addr = (state == S_FETCH) ? pos[ADDR_W-1:0] : pos_inc[ADDR_W-1:0];

   always_ff @(posedge clk_sys) begin
      if (sel && dn.dn_wr) mem[dn.dn_addr] <= dn.dn_data;
      else if (rd_en)      rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state != S_LOAD && sel)         state_nxt = S_LOAD;
      else if (state != S_LOAD && rewind) state_nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE:  if (motor && (pos < length)) state_nxt = S_FETCH;
            S_LOAD:  if (!dn.dn_go)               state_nxt = S_IDLE;
            S_FETCH: if (fetch_ph)                state_nxt = S_CELL;
            S_CELL:  if (tape_end)                state_nxt = S_DONE;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state == S_FETCH) || (state == S_CELL);
      done      = (state == S_DONE);
      dbg_state = state;
   end

   always_comb begin
      t_nxt       = t;
      bit_cnt_nxt = bit_cnt;
      sr_nxt      = sr;
      pos_nxt     = pos;
      length_nxt  = length;
      if (state != S_LOAD && sel) begin
         length_nxt = '0;
         pos_nxt    = '0;
         t_nxt      = '0;
      end else if (state != S_LOAD && rewind) begin
         pos_nxt = '0;
         t_nxt   = '0;
      end else if (state == S_FETCH && fetch_ph) begin
         sr_nxt      = rd_q;
         bit_cnt_nxt = 3'd7;
         t_nxt       = '0;
      end else if (adv) begin
         if (!cell_end) t_nxt = t + T_ONE;
         else begin
            t_nxt = '0;
            if (bit_cnt != 3'd0) begin
               sr_nxt      = {sr[6:0], 1'b0};
               bit_cnt_nxt = bit_cnt - 3'd1;
            end else begin
               pos_nxt     = pos_inc;
               sr_nxt      = rd_q;
               bit_cnt_nxt = 3'd7;
            end
         end
      end
      if (sel && dn.dn_wr && (length_nxt < wr_end)) length_nxt = wr_end;
      // Level is derived from the values the cell will hold next cycle, so the
      // first clock pulse appears on the cycle CELL is entered.
      cas_nxt = 1'b0;
      if (state_nxt == S_CELL && motor)
         cas_nxt = (t_nxt < T_PULSE) ||
                   (sr_nxt[7] && (t_nxt >= T_DATA0) && (t_nxt < T_DATA1));
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         t        <= '0;
         bit_cnt  <= 3'd0;
         sr       <= 8'd0;
         pos      <= '0;
         length   <= '0;
         fetch_ph <= 1'b0;
         cas_bit  <= 1'b0;
      end else begin
         t        <= t_nxt;
         bit_cnt  <= bit_cnt_nxt;
         sr       <= sr_nxt;
         pos      <= pos_nxt;
         length   <= length_nxt;
         fetch_ph <= (state == S_FETCH) && (state_nxt == S_FETCH);
         cas_bit  <= cas_nxt;
      end
   end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player, run with a 10x shorter bit cell (356 ticks,
// 23-tick pulses) so a full three-byte tape fits a short simulation.
module tb_cas_player;

   localparam int CELL  = 356;
   localparam int PULSE = 23;
   localparam int HALF  = CELL / 2;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_FETCH = 3'd2,
                          ST_CELL = 3'd3, ST_DONE = 3'd4;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b0, motor = 1'b0, rewind = 1'b0;
   logic        cas_bit, busy, done;
   logic [14:0] length, pos;
   logic [2:0]  dbg_state;

   cas_player_if #(.ADDR_W(14)) dn_bus ();

   cas_player #(.ADDR_W(14), .CAS_IDX(8'd1), .CELL_T(CELL), .PULSE_T(PULSE)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ce        (ce),
      .dn        (dn_bus),
      .motor     (motor),
      .rewind    (rewind),
      .cas_bit   (cas_bit),
      .busy      (busy),
      .done      (done),
      .length    (length),
      .pos       (pos),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [0:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
         cyc++;
      end
   endtask

   function automatic logic pulse_at(input int k, input logic d);
      return (k < PULSE) || (d && k >= HALF && k < HALF + PULSE);
   endfunction

   task automatic run_ticks(input int from, input int to, input logic d, inout int errs);
      for (int k = from; k < to; k++) begin
         if (cas_bit !== pulse_at(k, d)) errs++;
         step();
      end
   endtask

   task automatic check_cell(input string tag);
      int   errs;
      logic d;
      errs = 0;
      d = exp_q.pop_front();
      run_ticks(0, CELL, d, errs);
      chk(tag, errs, 0);
   endtask

   // driver tasks for the download port
   task automatic dl_start(input logic [7:0] idx);
      dn_bus.dn_go  = 1'b1;
      dn_bus.dn_idx = idx;
      step();
   endtask

   task automatic dl_wr(input logic [13:0] a, input logic [7:0] d);
      dn_bus.dn_wr   = 1'b1;
      dn_bus.dn_addr = a;
      dn_bus.dn_data = d;
      step();
      dn_bus.dn_wr = 1'b0;
      step();
   endtask

   task automatic dl_end();
      dn_bus.dn_go = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] img [3];
      int   errs, perrs, highs, nidle, t0;
      logic d;
      img = '{8'h55, 8'hA5, 8'h00};
      dn_bus.dn_go = 1'b0; dn_bus.dn_wr = 1'b0; dn_bus.dn_addr = '0;
      dn_bus.dn_data = '0; dn_bus.dn_idx = '0;

      reset_n = 1'b0;
      step(3);
      chk("rst_cas", cas_bit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_len", length, 0);
      chk("rst_pos", pos, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      reset_n = 1'b1;
      step();

      // download written out of order: length is the max end address
      dl_start(8'd1);
      chk("load_state", dbg_state, ST_LOAD);
      chk("load_busy", busy, 0);
      dl_wr(14'd2, img[2]);
      chk("len_first_wr", length, 3);
      dl_wr(14'd0, img[0]);
      dl_wr(14'd1, img[1]);
      chk("len_after", length, 3);
      dl_end();
      chk("dl_idle", dbg_state, ST_IDLE);
      chk("dl_pos", pos, 0);
      chk("dl_busy", busy, 0);

      dl_start(8'd0);
      chk("idx0_state", dbg_state, ST_IDLE);
      for (int a = 0; a < 5; a++) dl_wr(14'(a), 8'hFF);
      dl_end();
      chk("idx0_len", length, 3);

      for (int b = 0; b < 3; b++)
         for (int i = 7; i >= 0; i--) exp_q.push_back(img[b][i]);

      // start latency: pulse on the third edge after motor rises
      ce = 1'b1;
      motor = 1'b1;
      step(2);
      chk("lat_2", cas_bit, 0);
      chk("fetch_busy", busy, 1);
      step();
      chk("lat_3", cas_bit, 1);
      chk("cell_state", dbg_state, ST_CELL);
      t0 = cyc;

      for (int c = 0; c < 3; c++) check_cell($sformatf("b0_c%0d", c));
      d = exp_q.pop_front();
      errs = 0;
      run_ticks(0, 185, d, errs);
      chk("pre_pause", cas_bit, 1);
      motor = 1'b0;
      perrs = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (cas_bit !== 1'b0) perrs++;
      end
      chk("pause_low", perrs, 0);
      chk("pause_pos", pos, 0);
      chk("pause_busy", busy, 1);
      motor = 1'b1;
      step();
      run_ticks(186, CELL, d, errs);
      chk("resume_c3", errs, 0);
      for (int c = 4; c < 8; c++) check_cell($sformatf("b0_c%0d", c));

      chk("pos_b1", pos, 1);
      for (int c = 0; c < 8; c++) check_cell($sformatf("b1_c%0d", c));
      chk("pos_b2", pos, 2);
      for (int c = 0; c < 7; c++) check_cell($sformatf("b2_c%0d", c));
      d = exp_q.pop_front();
      errs = 0;
      run_ticks(0, CELL - 1, d, errs);
      chk("last_cell", errs, 0);
      chk("pre_done", done, 0);
      step();
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_pos", pos, 3);
      chk("done_cas", cas_bit, 0);
      chk("done_state", dbg_state, ST_DONE);
      chk("done_time", cyc - t0, 24 * CELL + 500);
      step(50);
      chk("done_hold", done, 1);

      // rewind from DONE, replay up to byte 2, rewind again
      motor = 1'b0;
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      chk("rw0_pos", pos, 0);
      chk("rw0_done", done, 0);
      chk("rw0_state", dbg_state, ST_IDLE);
      motor = 1'b1;
      step(3 + 16 * CELL);
      chk("rw_pos2", pos, 2);
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      chk("rw_pos", pos, 0);
      chk("rw_state", dbg_state, ST_IDLE);
      chk("rw_cas", cas_bit, 0);
      step(2);
      chk("replay_lat2", cas_bit, 0);
      step();
      chk("replay_start", cas_bit, 1);
      chk("replay_pos", pos, 0);

      // half-rate ce stretches the clock pulse to two cycles per tick
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         if (cas_bit === 1'b1) highs++;
         ce = (i % 2 == 1);
         step();
      end
      ce = 1'b1;
      chk("ce_half_pulse", highs, 2 * PULSE);

      // selected download aborts playback the same cycle
      dl_start(8'd1);
      chk("abort_cas", cas_bit, 0);
      chk("abort_busy", busy, 0);
      chk("abort_len", length, 0);
      chk("abort_state", dbg_state, ST_LOAD);
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      chk("rw_in_load", dbg_state, ST_LOAD);
      dl_wr(14'd0, 8'h80);
      chk("reload_len", length, 1);
      motor = 1'b0;
      dl_end();
      chk("reload_idle", dbg_state, ST_IDLE);

      // empty tape never plays
      dl_start(8'd1);
      dl_end();
      chk("len0", length, 0);
      motor = 1'b1;
      highs = 0;
      nidle = 0;
      for (int i = 0; i < 10000; i++) begin
         step();
         if (cas_bit !== 1'b0) highs++;
         if (dbg_state !== ST_IDLE) nidle++;
      end
      chk("len0_pulses", highs, 0);
      chk("len0_idle", nidle, 0);
      chk("len0_done", done, 0);

      // reset mid-play
      dl_start(8'd1);
      dl_wr(14'd0, 8'hFF);
      dl_end();
      step(10);
      chk("mid_busy", busy, 1);
      reset_n = 1'b0;
      step();
      chk("mrst_busy", busy, 0);
      chk("mrst_len", length, 0);
      chk("mrst_pos", pos, 0);
      chk("mrst_cas", cas_bit, 0);
      chk("mrst_state", dbg_state, ST_IDLE);
      reset_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback engine for the HT1080Z/TRS-80 core. It captures a `.CAS` image streamed from `hps_io` during an OSD download into an internal byte buffer. When the CPU's cassette motor relay is on, it replays the image as a Level II 500-baud pulse train on the CPU cassette input. It sits between the `hps_io` ioctl download port and the `ht1080z` cassette-in pin, in the `clk_sys` (42 MHz) domain.

## Interface
Parameters:
- `ADDR_W`, 14: buffer address width; depth is 2^ADDR_W bytes (16 KB, matching `ioctl_addr`).
- `CAS_IDX`, 8'd1: `ioctl_index` value that selects this block.
- `CELL_T`, 3560: bit-cell length in `ce` ticks (2 ms at 1.78 MHz).
- `PULSE_T`, 228: pulse length in `ce` ticks (~128 µs).

Ports:
- `clk_sys`  in  1  system clock, 42 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `ce`  in  1  CPU clock enable; it scales with the overclock setting, so tape speed tracks the CPU.
- `dn_go`  in  1  download active (`ioctl_download`).
- `dn_wr`  in  1  one-cycle byte strobe (`ioctl_wr`).
- `dn_addr`  in  ADDR_W  byte address (`ioctl_addr`).
- `dn_data`  in  8  byte data.
- `dn_idx`  in  8  download index.
- `motor`  in  1  cassette relay from the CPU; 1 = play.
- `rewind`  in  1  one-cycle pulse that returns playback to byte 0.
- `cas_bit`  out  1  cassette input level to the CPU.
- `busy`  out  1  playing, or paused mid-tape.
- `done`  out  1  end of tape reached.
- `length`  out  ADDR_W+1  number of valid bytes in the buffer.
- `pos`  out  ADDR_W+1  index of the byte currently being played.

## Operation
- Download is selected when `dn_go`=1 and `dn_idx`=CAS_IDX.
  - On the first cycle of a selected download: `length`←0, `pos`←0, `done`←0, `busy`←0, `cas_bit`←0, and any playback is aborted.
  - On each `dn_wr`: buffer[`dn_addr`]←`dn_data`, and `length`←max(`length`, `dn_addr`+1).
  - Downloads with any other index are ignored, and playback continues.
- States: IDLE, LOAD, FETCH, CELL, DONE.
  - IDLE→LOAD on a selected download; LOAD→IDLE when `dn_go` falls.
  - IDLE→FETCH when `motor`=1 and `pos`<`length`. FETCH issues a buffer read of `pos`; the data is registered the next cycle into shift register `sr`, then the machine enters CELL with bit counter 7.
  - CELL runs on a tick counter `t` that advances only when `ce`=1 and `motor`=1, counting 0..CELL_T-1.
    - `cas_bit`=1 when `t`<PULSE_T (clock pulse).
    - `cas_bit`=1 when `sr`[7]=1 and CELL_T/2 ≤ `t` < CELL_T/2+PULSE_T (data pulse).
    - `cas_bit`=0 otherwise.
  - At the end of a cell (`t`=CELL_T-1 with the advancing tick): shift `sr` left and decrement the bit counter.
  - After bit 0: `pos`←`pos`+1. If the new `pos`=`length`, go to DONE; otherwise load `sr` from the prefetch register and start the next cell with `t`=0.
  - DONE: `done`=1, `busy`=0, `cas_bit`=0.
- Prefetch: the read of byte `pos`+1 is issued on the cycle the first cell of byte `pos` starts. Consecutive byte cells are therefore contiguous, with no gap ticks.
- Bit order is MSB first. The image is played verbatim; leader and sync bytes come from the file itself.
- `busy`=1 in FETCH and CELL.
- Pause: `motor`=0 in CELL freezes `t`, the bit counter and `pos`, and forces `cas_bit`=0. `motor`=1 resumes at the frozen tick.
- `rewind`: `pos`←0, `done`←0, state←IDLE, `cas_bit`←0. Rewind is ignored during LOAD.
- Writes with `dn_addr` ≥ 2^ADDR_W cannot occur; the width is enforced.
- `length`=0: the block stays in IDLE regardless of `motor`. `done` stays 0 and `cas_bit` stays 0.

## Timing
- Reset (`reset_n`=0 at a `clk_sys` edge) sets:
  - state=IDLE, `cas_bit`=0, `busy`=0, `done`=0, `length`=0, `pos`=0, `t`=0;
  - buffer contents are undefined.
- Buffer: single-port synchronous RAM with 1-cycle read latency. A write takes priority over a read on the same cycle; no read is issued in LOAD.
- Start latency: `motor` rising → first `cas_bit`=1 at 3 `clk_sys` cycles (IDLE→FETCH, read, CELL), independent of `ce`.
- `cas_bit` is registered. It changes one `clk_sys` cycle after the advancing `ce` tick that crosses a threshold.
- `done` rises on the same cycle the state enters DONE.
- Download starting while in CELL: the abort takes effect the same cycle, and `cas_bit`=0 on the next cycle.
- Reset asserted mid-download or mid-play: immediate return to the reset values.

## Test plan
- Download bytes 0x55, 0xA5, 0x00 with index 1 → `length`=3, `pos`=0, `busy`=0. The same download with index 0 → `length` unchanged.
- Play 0xA5 with `ce`=1 every cycle and `motor`=1 → 8 clock pulses of 228 cycles at 3560-cycle spacing; data pulses only in cells 0, 2, 5 and 7.
- Full 3-byte play → `pos` steps 0→1→2, with no gap between cells. `done`=1 and `busy`=0 exactly 24·3560 ticks after the first pulse.
- Drop `motor` at tick 1000 of cell 3, hold for 5000 cycles, then raise it → `cas_bit`=0 while paused; the cell resumes at tick 1000 and `pos` is unchanged.
- `rewind` while `pos`=2 → `pos`=0, IDLE; the next `motor`=1 replays byte 0.
- Selected download starting while in CELL → `cas_bit`=0 and `busy`=0 the next cycle, `length` restarts from 0. Separately, with `length`=0 and `motor`=1 held for 10000 cycles → no pulses.
